// File: rtl/cpu_pkg.sv
// Shared encodings for the parametrised CPU execution unit: ALU opcodes,
// S-operand source selects and status-bit positions.
package cpu_pkg;

  typedef enum logic [3:0] {
    ALU_PASS_R     = 4'h0,
    ALU_PASS_S     = 4'h1,
    ALU_ADD        = 4'h2,
    ALU_SUB        = 4'h3,
    ALU_INC        = 4'h4,
    ALU_DEC        = 4'h5,
    ALU_AND        = 4'h6,
    ALU_OR         = 4'h7,
    ALU_XOR        = 4'h8,
    ALU_NOT        = 4'h9,
    ALU_SHL        = 4'hA,
    ALU_SHR        = 4'hB,
    ALU_ASR        = 4'hC,
    ALU_ZERO       = 4'hD,
    ALU_ONES       = 4'hE,
    ALU_PASS_R_ALT = 4'hF
  } alu_op_e;

  typedef enum logic [1:0] {
    SSEL_REG  = 2'd0,
    SSEL_DIN  = 2'd1,
    SSEL_LINK = 2'd2,
    SSEL_OFF  = 2'd3
  } ssel_e;

  localparam int unsigned ST_N = 2;
  localparam int unsigned ST_Z = 1;
  localparam int unsigned ST_C = 0;

endpackage

// File: rtl/reg_inc_ld_w.sv
// Width-parametrised register with sync active-low reset, load and increment;
// simultaneous load and increment holds the current value.
module reg_inc_ld_w #(
  parameter int unsigned     W       = 16,
  parameter logic [W-1:0]    RST_VAL = '0
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_ld,
  input  logic         i_inc,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n)
      o_q <= RST_VAL;
    else if (i_ld && !i_inc)
      o_q <= i_d;
    else if (i_inc && !i_ld)
      o_q <= o_q + W'(1);
  end

endmodule

// File: rtl/cpu_eu_param.sv
// Parametrised CPU execution unit: register file, ALU with registered status,
// PC/IR registers, link register and selectable S-operand source.
module cpu_eu_param
  import cpu_pkg::*;
#(
  parameter int unsigned        DATA_W  = 16,
  parameter int unsigned        REG_CNT = 8,
  parameter int unsigned        IMM_W   = 8,
  parameter logic [DATA_W-1:0]  RST_PC  = '0,
  localparam int unsigned       ADR_W   = $clog2(REG_CNT)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADR_W-1:0]  W_Adr,
  input  logic [ADR_W-1:0]  R_Adr,
  input  logic [ADR_W-1:0]  S_Adr,
  input  logic [3:0]        Alu_Op,
  input  logic              W_En,
  input  logic [1:0]        S_Sel,
  input  logic              adr_sel,
  input  logic              flag_ld,
  input  logic              pc_sel,
  input  logic              pc_ld,
  input  logic              pc_inc,
  input  logic              link_en,
  input  logic              ir_ld,
  input  logic [DATA_W-1:0] D_in,
  output logic [DATA_W-1:0] Address,
  output logic [DATA_W-1:0] D_out,
  output logic [DATA_W-1:0] ir_out,
  output logic [DATA_W-1:0] link_out,
  output logic [2:0]        ALU_Status,
  output logic [2:0]        status_q
);

  logic [DATA_W-1:0] r_rf [REG_CNT];
  logic [DATA_W-1:0] r_link;
  logic [2:0]        r_status;
  logic [DATA_W-1:0] w_pc;
  logic [DATA_W-1:0] w_pc_d;
  logic [DATA_W-1:0] w_off;
  logic [DATA_W-1:0] w_r;
  logic [DATA_W-1:0] w_s;
  logic [DATA_W-1:0] w_res;
  logic [DATA_W:0]   w_sum;
  logic              w_c;
  logic              w_pc_load;

  // Register file: async read, no write-to-read bypass.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int unsigned i = 0; i < REG_CNT; i++) r_rf[i] <= '0;
    end else if (W_En) begin
      r_rf[W_Adr] <= D_out;
    end
  end

  assign w_r   = r_rf[R_Adr];
  assign w_off = DATA_W'($signed(ir_out[IMM_W-1:0]));

  always_comb begin
    w_s = r_rf[S_Adr];
    unique case (ssel_e'(S_Sel))
      SSEL_REG:  w_s = r_rf[S_Adr];
      SSEL_DIN:  w_s = D_in;
      SSEL_LINK: w_s = r_link;
      SSEL_OFF:  w_s = w_off;
      default:   w_s = r_rf[S_Adr];
    endcase
  end

  // Carry/borrow comes from a (DATA_W+1)-bit computation.
  always_comb begin
    w_res = '0;
    w_c   = 1'b0;
    w_sum = '0;
    unique case (alu_op_e'(Alu_Op))
      ALU_PASS_R, ALU_PASS_R_ALT: w_res = w_r;
      ALU_PASS_S: w_res = w_s;
      ALU_ADD: begin
        w_sum = {1'b0, w_r} + {1'b0, w_s};
        w_res = w_sum[DATA_W-1:0];
        w_c   = w_sum[DATA_W];
      end
      ALU_SUB: begin
        w_sum = {1'b0, w_r} - {1'b0, w_s};
        w_res = w_sum[DATA_W-1:0];
        w_c   = w_sum[DATA_W];
      end
      ALU_INC: begin
        w_sum = {1'b0, w_s} + (DATA_W+1)'(1);
        w_res = w_sum[DATA_W-1:0];
        w_c   = w_sum[DATA_W];
      end
      ALU_DEC: begin
        w_sum = {1'b0, w_s} - (DATA_W+1)'(1);
        w_res = w_sum[DATA_W-1:0];
        w_c   = w_sum[DATA_W];
      end
      ALU_AND:  w_res = w_r & w_s;
      ALU_OR:   w_res = w_r | w_s;
      ALU_XOR:  w_res = w_r ^ w_s;
      ALU_NOT:  w_res = ~w_s;
      ALU_SHL: begin
        w_res = {w_s[DATA_W-2:0], 1'b0};
        w_c   = w_s[DATA_W-1];
      end
      ALU_SHR: begin
        w_res = {1'b0, w_s[DATA_W-1:1]};
        w_c   = w_s[0];
      end
      ALU_ASR: begin
        w_res = {w_s[DATA_W-1], w_s[DATA_W-1:1]};
        w_c   = w_s[0];
      end
      ALU_ZERO: w_res = '0;
      ALU_ONES: w_res = '1;
      default:  w_res = w_r;
    endcase
  end

  assign D_out            = w_res;
  assign ALU_Status[ST_N] = w_res[DATA_W-1];
  assign ALU_Status[ST_Z] = (w_res == '0);
  assign ALU_Status[ST_C] = w_c;

  assign w_pc_load = pc_ld && !pc_inc;
  assign w_pc_d    = pc_sel ? D_out : (w_pc + w_off);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_status <= '0;
      r_link   <= '0;
    end else begin
      if (flag_ld)              r_status <= ALU_Status;
      if (w_pc_load && link_en) r_link   <= w_pc;
    end
  end

  reg_inc_ld_w #(.W(DATA_W), .RST_VAL(RST_PC)) u_pc (
    .i_clk   (clk),
    .i_rst_n (reset),
    .i_ld    (pc_ld),
    .i_inc   (pc_inc),
    .i_d     (w_pc_d),
    .o_q     (w_pc)
  );

  reg_inc_ld_w #(.W(DATA_W), .RST_VAL('0)) u_ir (
    .i_clk   (clk),
    .i_rst_n (reset),
    .i_ld    (ir_ld),
    .i_inc   (1'b0),
    .i_d     (D_in),
    .o_q     (ir_out)
  );

  assign Address  = adr_sel ? w_r : w_pc;
  assign link_out = r_link;
  assign status_q = r_status;

endmodule

// File: tb/tb_cpu_eu_param.sv
// Self-checking bench for cpu_eu_param: directed scenarios plus randomized
// cycles against an arithmetic reference model; a second 32-bit instance.
module tb_cpu_eu_param;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // Default 16-bit instance
  logic        reset;
  logic [2:0]  W_Adr, R_Adr, S_Adr;
  logic [3:0]  Alu_Op;
  logic        W_En, adr_sel, flag_ld, pc_sel, pc_ld, pc_inc, link_en, ir_ld;
  logic [1:0]  S_Sel;
  logic [15:0] D_in, Address, D_out, ir_out, link_out;
  logic [2:0]  ALU_Status, status_q;

  cpu_eu_param dut (
    .clk(clk), .reset(reset), .W_Adr(W_Adr), .R_Adr(R_Adr), .S_Adr(S_Adr),
    .Alu_Op(Alu_Op), .W_En(W_En), .S_Sel(S_Sel), .adr_sel(adr_sel),
    .flag_ld(flag_ld), .pc_sel(pc_sel), .pc_ld(pc_ld), .pc_inc(pc_inc),
    .link_en(link_en), .ir_ld(ir_ld), .D_in(D_in), .Address(Address),
    .D_out(D_out), .ir_out(ir_out), .link_out(link_out),
    .ALU_Status(ALU_Status), .status_q(status_q)
  );

  // Wide instance: DATA_W=32, REG_CNT=16, IMM_W=12
  logic        p_reset;
  logic [3:0]  p_W_Adr, p_R_Adr, p_S_Adr;
  logic [3:0]  p_Alu_Op;
  logic        p_W_En, p_adr_sel, p_flag_ld, p_pc_sel, p_pc_ld, p_pc_inc, p_link_en, p_ir_ld;
  logic [1:0]  p_S_Sel;
  logic [31:0] p_D_in, p_Address, p_D_out, p_ir_out, p_link_out;
  logic [2:0]  p_ALU_Status, p_status_q;

  cpu_eu_param #(.DATA_W(32), .REG_CNT(16), .IMM_W(12), .RST_PC(32'h0)) dut32 (
    .clk(clk), .reset(p_reset), .W_Adr(p_W_Adr), .R_Adr(p_R_Adr), .S_Adr(p_S_Adr),
    .Alu_Op(p_Alu_Op), .W_En(p_W_En), .S_Sel(p_S_Sel), .adr_sel(p_adr_sel),
    .flag_ld(p_flag_ld), .pc_sel(p_pc_sel), .pc_ld(p_pc_ld), .pc_inc(p_pc_inc),
    .link_en(p_link_en), .ir_ld(p_ir_ld), .D_in(p_D_in), .Address(p_Address),
    .D_out(p_D_out), .ir_out(p_ir_out), .link_out(p_link_out),
    .ALU_Status(p_ALU_Status), .status_q(p_status_q)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference architectural state (16-bit instance)
  int m_reg [8];
  int m_pc, m_ir, m_link, m_st;

  // Returns {flags[2:0], result[15:0]} from integer arithmetic on the op table.
  function automatic logic [18:0] ref_alu(int op, int r, int s);
    int res;
    bit c;
    logic [15:0] rv;
    c = 1'b0;
    case (op)
      1:  res = s;
      2:  begin res = r + s; c = (res > 65535); end
      3:  begin res = r - s; c = (r < s); end
      4:  begin res = s + 1; c = (s == 65535); end
      5:  begin res = s - 1; c = (s == 0); end
      6:  res = r & s;
      7:  res = r | s;
      8:  res = r ^ s;
      9:  res = 65535 - s;
      10: begin res = s * 2; c = (s >= 32768); end
      11: begin res = s / 2; c = (s % 2) != 0; end
      12: begin res = s / 2 + ((s >= 32768) ? 32768 : 0); c = (s % 2) != 0; end
      13: res = 0;
      14: res = 65535;
      default: res = r;
    endcase
    res = res & 65535;
    rv  = res[15:0];
    return {rv[15], (res == 0), c, rv};
  endfunction

  function automatic int ref_s();
    int off;
    off = m_ir & 255;
    if (off >= 128) off = off - 256;
    case (S_Sel)
      2'd0:    return m_reg[S_Adr];
      2'd1:    return int'(D_in);
      2'd2:    return m_link;
      default: return off & 65535;
    endcase
  endfunction

  function automatic logic [18:0] ref_now();
    return ref_alu(int'(Alu_Op), m_reg[R_Adr], ref_s());
  endfunction

  function automatic int ref_addr();
    return adr_sel ? m_reg[R_Adr] : m_pc;
  endfunction

  // Advance the model by one clock using current inputs, then clock the DUT.
  task automatic cycle();
    logic [18:0] a;
    int res, off;
    a   = ref_now();
    res = int'(a[15:0]);
    off = m_ir & 255;
    if (off >= 128) off = off - 256;
    if (!reset) begin
      foreach (m_reg[i]) m_reg[i] = 0;
      m_pc = 0; m_ir = 0; m_link = 0; m_st = 0;
    end else begin
      if (W_En) m_reg[W_Adr] = res;
      if (flag_ld) m_st = int'(a[18:16]);
      if (pc_ld && !pc_inc) begin
        if (link_en) m_link = m_pc;
        m_pc = pc_sel ? res : ((m_pc + off) & 65535);
      end else if (pc_inc && !pc_ld) begin
        m_pc = (m_pc + 1) & 65535;
      end
      if (ir_ld) m_ir = int'(D_in);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    W_En = 0; flag_ld = 0; pc_ld = 0; pc_inc = 0; link_en = 0; ir_ld = 0;
    pc_sel = 0; adr_sel = 0; S_Sel = 2'd0; Alu_Op = 4'd0;
    W_Adr = 0; R_Adr = 0; S_Adr = 0; D_in = 16'h0;
  endtask

  task automatic test_reset();
    reset = 0;
    W_En = 1; flag_ld = 1; pc_ld = 1; pc_inc = 0; link_en = 1; ir_ld = 1;
    pc_sel = 1; S_Sel = 2'd1; Alu_Op = 4'hE; D_in = 16'hA5A5; W_Adr = 3'd4;
    cycle();
    cycle();
    idle();
    reset = 1;
    #1;
    n_checks++; if (Address !== 16'h0) begin n_errors++; $display("FAIL reset_pc got %h exp 0000", Address); end
    n_checks++; if (ir_out !== 16'h0) begin n_errors++; $display("FAIL reset_ir got %h exp 0000", ir_out); end
    n_checks++; if (link_out !== 16'h0) begin n_errors++; $display("FAIL reset_link got %h exp 0000", link_out); end
    n_checks++; if (status_q !== 3'b000) begin n_errors++; $display("FAIL reset_status got %b exp 000", status_q); end
    adr_sel = 1;
    for (int i = 0; i < 8; i++) begin
      R_Adr = 3'(i);
      #1;
      n_checks++; if (Address !== 16'h0) begin n_errors++; $display("FAIL reset_reg%0d got %h exp 0000", i, Address); end
    end
    idle();
  endtask

  task automatic test_add_flags();
    idle();
    S_Sel = 2'd1; D_in = 16'h7FFF; Alu_Op = 4'h1; W_En = 1; W_Adr = 3'd1;
    cycle();
    idle();
    R_Adr = 3'd1; S_Sel = 2'd1; D_in = 16'h0001; Alu_Op = 4'h2; flag_ld = 1; adr_sel = 1;
    #1;
    n_checks++; if (Address !== 16'h7FFF) begin n_errors++; $display("FAIL reg1_write got %h exp 7fff", Address); end
    n_checks++; if (D_out !== 16'h8000) begin n_errors++; $display("FAIL add_result got %h exp 8000", D_out); end
    n_checks++; if (ALU_Status !== 3'b100) begin n_errors++; $display("FAIL add_flags got %b exp 100", ALU_Status); end
    n_checks++; if (status_q !== 3'b000) begin n_errors++; $display("FAIL status_before_edge got %b exp 000", status_q); end
    cycle();
    flag_ld = 0;
    #1;
    n_checks++; if (status_q !== 3'b100) begin n_errors++; $display("FAIL status_q_load got %b exp 100", status_q); end
    idle();
  endtask

  task automatic test_borrow_zero();
    idle();
    S_Sel = 2'd1; D_in = 16'h0005; Alu_Op = 4'h1; W_En = 1; W_Adr = 3'd2;
    cycle();
    idle();
    R_Adr = 3'd2; S_Sel = 2'd1; D_in = 16'h0005; Alu_Op = 4'h3;
    #1;
    n_checks++; if (D_out !== 16'h0000) begin n_errors++; $display("FAIL sub_zero got %h exp 0000", D_out); end
    n_checks++; if (ALU_Status !== 3'b010) begin n_errors++; $display("FAIL sub_zero_flags got %b exp 010", ALU_Status); end
    D_in = 16'h0006;
    #1;
    n_checks++; if (D_out !== 16'hFFFF) begin n_errors++; $display("FAIL sub_borrow got %h exp ffff", D_out); end
    n_checks++; if (ALU_Status !== 3'b101) begin n_errors++; $display("FAIL sub_borrow_flags got %b exp 101", ALU_Status); end
    idle();
  endtask

  task automatic test_branch_link();
    idle();
    S_Sel = 2'd1; Alu_Op = 4'h1; D_in = 16'h0010; pc_ld = 1; pc_sel = 1;
    cycle();
    idle();
    ir_ld = 1; D_in = 16'h00FE;
    cycle();
    idle();
    pc_ld = 1; pc_sel = 0; link_en = 1;
    cycle();
    idle();
    #1;
    n_checks++; if (Address !== 16'h000E) begin n_errors++; $display("FAIL branch_pc got %h exp 000e", Address); end
    n_checks++; if (link_out !== 16'h0010) begin n_errors++; $display("FAIL branch_link got %h exp 0010", link_out); end
    n_checks++; if (ir_out !== 16'h00FE) begin n_errors++; $display("FAIL ir_load got %h exp 00fe", ir_out); end
    S_Sel = 2'd2; Alu_Op = 4'h1;
    #1;
    n_checks++; if (D_out !== 16'h0010) begin n_errors++; $display("FAIL link_as_s got %h exp 0010", D_out); end
    S_Sel = 2'd3;
    #1;
    n_checks++; if (D_out !== 16'hFFFE) begin n_errors++; $display("FAIL offset_as_s got %h exp fffe", D_out); end
    idle();
  endtask

  task automatic test_pc_edges();
    idle();
    pc_ld = 1; pc_inc = 1; pc_sel = 1; S_Sel = 2'd1; Alu_Op = 4'h1; D_in = 16'h5555; link_en = 1;
    cycle();
    idle();
    #1;
    n_checks++; if (Address !== 16'h000E) begin n_errors++; $display("FAIL pc_conflict_hold got %h exp 000e", Address); end
    n_checks++; if (link_out !== 16'h0010) begin n_errors++; $display("FAIL link_no_load got %h exp 0010", link_out); end
    S_Sel = 2'd1; Alu_Op = 4'h1; D_in = 16'hFFFF; pc_ld = 1; pc_sel = 1;
    cycle();
    idle();
    pc_inc = 1;
    cycle();
    idle();
    #1;
    n_checks++; if (Address !== 16'h0000) begin n_errors++; $display("FAIL pc_wrap got %h exp 0000", Address); end
    S_Sel = 2'd1; Alu_Op = 4'h1; D_in = 16'h1234; pc_ld = 1; pc_sel = 1; link_en = 0;
    cycle();
    idle();
    #1;
    n_checks++; if (Address !== 16'h1234) begin n_errors++; $display("FAIL pc_from_alu got %h exp 1234", Address); end
    n_checks++; if (link_out !== 16'h0010) begin n_errors++; $display("FAIL link_hold got %h exp 0010", link_out); end
  endtask

  task automatic test_back_to_back();
    idle();
    S_Sel = 2'd1; Alu_Op = 4'h1; D_in = 16'h0ABC; W_En = 1; W_Adr = 3'd3; pc_ld = 1; pc_sel = 1;
    cycle();
    idle();
    R_Adr = 3'd3; adr_sel = 1;
    #1;
    n_checks++; if (Address !== 16'h0ABC) begin n_errors++; $display("FAIL shared_dout_reg got %h exp 0abc", Address); end
    adr_sel = 0;
    #1;
    n_checks++; if (Address !== 16'h0ABC) begin n_errors++; $display("FAIL shared_dout_pc got %h exp 0abc", Address); end
    // Same-cycle read of the register being written sees the old value.
    R_Adr = 3'd3; W_Adr = 3'd3; W_En = 1; S_Sel = 2'd1; D_in = 16'h0001; Alu_Op = 4'h2;
    #1;
    n_checks++; if (D_out !== 16'h0ABD) begin n_errors++; $display("FAIL no_bypass got %h exp 0abd", D_out); end
    cycle();
    #1;
    n_checks++; if (D_out !== 16'h0ABE) begin n_errors++; $display("FAIL rmw_next got %h exp 0abe", D_out); end
    // Reset mid-sequence discards every enable in that cycle.
    reset = 0; pc_inc = 1; ir_ld = 1; flag_ld = 1; D_in = 16'h7777;
    cycle();
    reset = 1;
    idle();
    R_Adr = 3'd3; adr_sel = 1;
    #1;
    n_checks++; if (Address !== 16'h0000) begin n_errors++; $display("FAIL midreset_reg got %h exp 0000", Address); end
    adr_sel = 0;
    #1;
    n_checks++; if (Address !== 16'h0000) begin n_errors++; $display("FAIL midreset_pc got %h exp 0000", Address); end
    n_checks++; if (ir_out !== 16'h0000) begin n_errors++; $display("FAIL midreset_ir got %h exp 0000", ir_out); end
    idle();
  endtask

  task automatic test_random();
    logic [18:0] a;
    for (int it = 0; it < 300; it++) begin
      reset   = ($urandom_range(0, 39) != 0);
      W_Adr   = 3'($urandom); R_Adr = 3'($urandom); S_Adr = 3'($urandom);
      Alu_Op  = 4'($urandom); S_Sel = 2'($urandom); D_in = 16'($urandom);
      W_En    = 1'($urandom); adr_sel = 1'($urandom); flag_ld = 1'($urandom);
      pc_sel  = 1'($urandom); pc_ld = 1'($urandom); pc_inc = 1'($urandom);
      link_en = 1'($urandom); ir_ld = ($urandom_range(0, 3) == 0);
      #1;
      a = ref_now();
      n_checks++; if (D_out !== a[15:0]) begin n_errors++; $display("FAIL rnd_dout it%0d op%0h got %h exp %h", it, Alu_Op, D_out, a[15:0]); end
      n_checks++; if (ALU_Status !== a[18:16]) begin n_errors++; $display("FAIL rnd_flags it%0d op%0h got %b exp %b", it, Alu_Op, ALU_Status, a[18:16]); end
      n_checks++; if (Address !== 16'(ref_addr())) begin n_errors++; $display("FAIL rnd_addr it%0d got %h exp %h", it, Address, 16'(ref_addr())); end
      cycle();
      n_checks++; if (ir_out !== 16'(m_ir)) begin n_errors++; $display("FAIL rnd_ir it%0d got %h exp %h", it, ir_out, 16'(m_ir)); end
      n_checks++; if (link_out !== 16'(m_link)) begin n_errors++; $display("FAIL rnd_link it%0d got %h exp %h", it, link_out, 16'(m_link)); end
      n_checks++; if (status_q !== 3'(m_st)) begin n_errors++; $display("FAIL rnd_status it%0d got %b exp %b", it, status_q, 3'(m_st)); end
      adr_sel = 0;
      #1;
      n_checks++; if (Address !== 16'(m_pc)) begin n_errors++; $display("FAIL rnd_pc it%0d got %h exp %h", it, Address, 16'(m_pc)); end
    end
    reset = 1;
    idle();
  endtask

  task automatic p_idle();
    p_W_En = 0; p_flag_ld = 0; p_pc_ld = 0; p_pc_inc = 0; p_link_en = 0; p_ir_ld = 0;
    p_pc_sel = 0; p_adr_sel = 0; p_S_Sel = 2'd0; p_Alu_Op = 4'd0;
    p_W_Adr = 0; p_R_Adr = 0; p_S_Adr = 0; p_D_in = 32'h0;
  endtask

  task automatic test_param_sweep();
    p_idle();
    p_reset = 0;
    @(posedge clk); #1;
    p_reset = 1;
    #1;
    n_checks++; if (p_Address !== 32'h0) begin n_errors++; $display("FAIL w32_reset_pc got %h exp 00000000", p_Address); end
    p_ir_ld = 1; p_D_in = 32'h0000_0800;
    @(posedge clk); #1;
    p_idle();
    p_S_Sel = 2'd1; p_Alu_Op = 4'h1; p_D_in = 32'h0000_0100; p_pc_ld = 1; p_pc_sel = 1;
    @(posedge clk); #1;
    p_idle();
    p_pc_ld = 1; p_pc_sel = 0; p_link_en = 1;
    @(posedge clk); #1;
    p_idle();
    #1;
    n_checks++; if (p_Address !== 32'hFFFF_F900) begin n_errors++; $display("FAIL w32_branch got %h exp fffff900", p_Address); end
    n_checks++; if (p_link_out !== 32'h0000_0100) begin n_errors++; $display("FAIL w32_link got %h exp 00000100", p_link_out); end
    p_S_Sel = 2'd1; p_Alu_Op = 4'h1; p_D_in = 32'hDEAD_BEEF; p_W_En = 1; p_W_Adr = 4'd15;
    @(posedge clk); #1;
    p_idle();
    p_R_Adr = 4'd15; p_adr_sel = 1; p_Alu_Op = 4'h0;
    #1;
    n_checks++; if (p_Address !== 32'hDEAD_BEEF) begin n_errors++; $display("FAIL w32_addr_reg15 got %h exp deadbeef", p_Address); end
    n_checks++; if (p_D_out !== 32'hDEAD_BEEF) begin n_errors++; $display("FAIL w32_read_reg15 got %h exp deadbeef", p_D_out); end
    n_checks++; if (p_ALU_Status !== 3'b100) begin n_errors++; $display("FAIL w32_flags got %b exp 100", p_ALU_Status); end
    p_Alu_Op = 4'hA;
    p_S_Sel = 2'd1; p_D_in = 32'h8000_0001;
    #1;
    n_checks++; if (p_D_out !== 32'h0000_0002 || p_ALU_Status !== 3'b001) begin
      n_errors++; $display("FAIL w32_shl got %h/%b exp 00000002/001", p_D_out, p_ALU_Status);
    end
    p_idle();
  endtask

  initial begin
    foreach (m_reg[i]) m_reg[i] = 0;
    m_pc = 0; m_ir = 0; m_link = 0; m_st = 0;
    reset = 1; idle();
    p_reset = 1; p_idle();
    @(posedge clk); #1;
    test_reset();
    test_add_flags();
    test_borrow_zero();
    test_branch_link();
    test_pc_edges();
    test_back_to_back();
    test_random();
    test_param_sweep();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/cpu_eu_param.md
Name: cpu_eu_param

Overview:
Parametrised successor of the 16-bit CPU execution unit. Contains:
- register file
- ALU with registered status
- PC and IR registers
- link register
- selectable S-operand source

Width, register count and branch-offset width are generics. The block sits between the control unit (all selects/enables) and the memory interface (Address, D_in, D_out).

Parameters:
DATA_W, 16, datapath, PC, IR and register width (>=8)
REG_CNT, 8, register-file entries (power of two, >=2); ADR_W = clog2(REG_CNT)
IMM_W, 8, PC-relative offset field width, taken from ir_out[IMM_W-1:0] (IMM_W <= DATA_W)
RST_PC, 0, PC value loaded on reset

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-low reset
W_Adr  in  ADR_W  register-file write address
R_Adr  in  ADR_W  R operand read address
S_Adr  in  ADR_W  S operand read address
Alu_Op  in  4  ALU function select
W_En  in  1  register-file write enable
S_Sel  in  2  S source: 0 regfile S, 1 D_in, 2 link, 3 sign-extended IR offset
adr_sel  in  1  Address source: 0 PC, 1 R operand
flag_ld  in  1  load status register from ALU flags
pc_sel  in  1  PC load source: 0 PC + offset, 1 ALU result
pc_ld  in  1  PC load
pc_inc  in  1  PC increment
link_en  in  1  capture PC into link register on a PC load
ir_ld  in  1  IR load from D_in
D_in  in  DATA_W  memory read data
Address  out  DATA_W  memory address
D_out  out  DATA_W  ALU result (combinational)
ir_out  out  DATA_W  IR contents
link_out  out  DATA_W  link register contents
ALU_Status  out  3  combinational flags {N,Z,C}
status_q  out  3  registered flags {N,Z,C}

Behaviour:
- Reset: sampled on the clk edge while reset==0. Loads PC=RST_PC and clears IR, link, status_q and every register-file entry to 0. Reset dominates all enables.
- Register file reads: asynchronous. Write occurs on the clk edge when W_En=1, data = D_out. A same-cycle read of W_Adr returns the old value; no bypass.
- Offset: off = sign-extend(ir_out[IMM_W-1:0]) to DATA_W.
- ALU operands: R = reg[R_Adr]; S chosen by S_Sel.
- Arithmetic: all modulo 2^DATA_W. C is the carry/borrow bit from a (DATA_W+1)-bit computation.
- Alu_Op encoding:
  - 0 pass R
  - 1 pass S
  - 2 R+S
  - 3 R-S (C=1 on borrow)
  - 4 S+1
  - 5 S-1 (C=1 on borrow)
  - 6 R&S
  - 7 R|S
  - 8 R^S
  - 9 ~S
  - A S<<1 (C = S msb)
  - B S>>1 logical (C = S lsb)
  - C S>>>1 arithmetic (C = S lsb)
  - D zero
  - E all-ones
  - F pass R
- Flags: C=0 for logic, pass and constant ops. N = D_out msb. Z = (D_out==0).
- status_q: loads ALU_Status when flag_ld=1, otherwise holds.
- Address: PC when adr_sel=0, R operand when adr_sel=1.
- PC (one cycle latency):
  - pc_ld=1, pc_inc=0: PC <= (pc_sel ? D_out : PC + off).
  - pc_ld=0, pc_inc=1: PC <= PC + 1; wraps from all-ones to 0.
  - Both 0 or both 1: PC holds.
- Link register: on a PC load (pc_ld=1, pc_inc=0, link_en=1), link <= current PC (pre-load value). Otherwise it holds; link_en is ignored when no load occurs.
- IR: ir_ld=1 loads D_in; no increment.
- Simultaneous W_En and PC load with pc_sel=1: both use the same D_out; this is legal.
- Reset asserted mid-sequence: all pending enables in that cycle are discarded.

Decomposition:
- Shared package cpu_pkg holds:
  - ALU opcode constants (ALU_PASS_R..ALU_ONES)
  - S_Sel constants (SSEL_REG, SSEL_DIN, SSEL_LINK, SSEL_OFF)
  - status bit indices (ST_N=2, ST_Z=1, ST_C=0)
- One natural sub-module: reg_inc_ld_w, a DATA_W-parametrised register with sync active-low reset, load, increment and hold-on-conflict. It is instantiated for PC (reset value RST_PC) and IR.
- The register file and ALU stay inline.

Test Plan:
- Reset: hold reset=0 for 2 cycles with all enables 1 -> PC=RST_PC(0), ir_out=0, link_out=0, status_q=0, all registers 0.
- Load/add/flags:
  - S_Sel=1, D_in=0x7FFF, Alu_Op=1, W_En=1, W_Adr=1 -> reg1=0x7FFF.
  - Next: R_Adr=1, D_in=0x0001, Alu_Op=2, flag_ld=1 -> D_out=0x8000, ALU_Status=3'b100, status_q=3'b100 one edge later.
- Borrow/zero: reg2=0x0005, S_Sel=1, D_in=0x0005, R_Adr=2, Alu_Op=3 -> D_out=0, {N,Z,C}=3'b010. Then D_in=6 -> D_out=0xFFFF, {N,Z,C}=3'b101.
- PC-relative branch with link:
  - PC=0x0010, ir_out=0x00FE, pc_ld=1, pc_sel=0, link_en=1 -> PC=0x000E, link_out=0x0010.
  - Then S_Sel=2, Alu_Op=1 -> D_out=0x0010.
- PC control edges:
  - pc_ld=pc_inc=1 -> PC unchanged.
  - PC=0xFFFF with pc_inc=1 -> PC=0x0000.
  - pc_sel=1 with D_out=0x1234 -> PC=0x1234, and link unchanged when link_en=0.
- Parameter sweep (DATA_W=32, REG_CNT=16, IMM_W=12): ir_out=0x00000800 and PC=0x100 with a PC load -> PC=0xFFFFF900. Also write/readback reg15 = 0xDEADBEEF, and confirm Address = reg15 with adr_sel=1.
